fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_ctrl_if.sv | 30 +++
 rtl/fetch_ctrl_pc_mux.sv | 26 ++
 rtl/fetch_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   fetch_state_t : fetch FSM states (BOOT, FETCH, REDIRECT)
//   PC_STEP       : byte distance between sequential instructions
//   BRCNT_WIDTH   : width of the optional taken-branch counter
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP     = 4;
  localparam int unsigned BRCNT_WIDTH = 16;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/response bus between fetch and imem.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : fetch address (master -> slave)
//   imem_ready : rdata valid this cycle (slave -> master)
//   imem_rdata : fetched instruction word (slave -> master)
interface fetch_ctrl_if #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32
) ();

  logic                     imem_req;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic                     imem_ready;
  logic [DATA_WIDTH-1:0]    imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_ctrl_pc_mux.sv
// Next-PC selector: sequential step or branch target from one base operand.
//   pcsrc   : 1 selects base + immext, 0 selects base + PC_STEP
//   base    : current pc or resolving-branch pc (selected upstream)
//   immext  : sign-extended branch offset
//   next_pc : selected next pc, wrapping modulo 2^ADDRESS_WIDTH
module pc_mux
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     pcsrc,
  input  logic [ADDRESS_WIDTH-1:0] base,
  input  logic [DATA_WIDTH-1:0]    immext,
  output logic [ADDRESS_WIDTH-1:0] next_pc
);

  // Only the low address bits of the sum survive, so truncating immext first is exact.
  always_comb begin
    next_pc = base + ADDRESS_WIDTH'(PC_STEP);
    if (pcsrc) begin
      next_pc = ADDRESS_WIDTH'(immext) + base;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: sequences pc, issues imem requests, hands
// fetched words to decode and handles branch redirects.
//   clk, rst         : clock, synchronous active-high reset
//   stall            : decode hazard hold, freezes fetch
//   redirect_valid   : taken branch resolved this cycle (highest priority)
//   redirect_base    : pc of the resolving branch
//   immext           : sign-extended branch offset
//   imem             : instruction-memory bus (master side)
//   instr/instr_pc   : instruction word and its pc for decode
//   instr_valid      : instr is valid
//   flush            : kill the younger instruction in decode
//   branch_count     : saturating redirect counter, only with FETCH_CTRL_BRCNT_EN
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_base,
  input  logic [DATA_WIDTH-1:0]    immext,
  fetch_ctrl_if.master             imem,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  output logic                     instr_valid,
  output logic                     flush
`ifdef FETCH_CTRL_BRCNT_EN
  ,
  output logic [BRCNT_WIDTH-1:0]   branch_count
`endif
);

  fetch_state_t             state;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic [ADDRESS_WIDTH-1:0] mux_base;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic                     req_c;

  // A redirect computes its target from the branch pc, otherwise we step from pc.
  assign mux_base = redirect_valid ? redirect_base : pc;

  pc_mux #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_pc_mux (
    .pcsrc   (redirect_valid),
    .base    (mux_base),
    .immext  (immext),
    .next_pc (next_pc)
  );

  // Request is combinational so a same-cycle ready gives one-cycle latency.
  assign req_c          = (state == FETCH) && !rst && !stall && !redirect_valid;
  assign imem.imem_req  = req_c;
  assign imem.imem_addr = pc;

  // Fetch FSM with registered decode-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      flush       <= 1'b0;
    end else begin
      flush <= 1'b0;
      if (redirect_valid) begin
        state       <= REDIRECT;
        pc          <= next_pc;
        instr_valid <= 1'b0;
        flush       <= 1'b1;
      end else begin
        case (state)
          BOOT: begin
            state <= FETCH;
          end
          FETCH: begin
            if (req_c && imem.imem_ready) begin
              instr       <= imem.imem_rdata;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              pc          <= next_pc;
            end else if (!stall) begin
              instr_valid <= 1'b0;
            end
          end
          REDIRECT: begin
            state <= FETCH;
          end
          default: begin
            state <= BOOT;
          end
        endcase
      end
    end
  end

`ifdef FETCH_CTRL_BRCNT_EN
  // Saturating count of cycles with a taken redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count <= '0;
    end else if (redirect_valid && (branch_count != '1)) begin
      branch_count <= branch_count + BRCNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed spec scenarios plus random
// traffic, all checked against a cycle-level behavioural model.
module tb_fetch_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall;
  logic          redirect_valid;
  logic [AW-1:0] redirect_base;
  logic [DW-1:0] immext;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          flush;
`ifdef FETCH_CTRL_BRCNT_EN
  logic [15:0]   branch_count;
`endif

  fetch_ctrl_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) imem_bus ();

  fetch_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_base  (redirect_base),
    .immext         (immext),
    .imem           (imem_bus),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .flush          (flush)
`ifdef FETCH_CTRL_BRCNT_EN
    ,
    .branch_count   (branch_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: what decode should see, and how many cycles since reset/redirect.
  int unsigned m_pc;
  int unsigned m_instr_pc;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_first_after_rst;
  bit          m_just_redirected;
  int unsigned m_brcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs, then advance the model at posedge.
  task automatic step(input bit r, input bit st, input bit rv, input logic [7:0] base,
                      input logic [31:0] imm, input bit rdy, input logic [31:0] rdata);
    bit exp_req;
    @(negedge clk);
    rst = r;
    stall = st;
    redirect_valid = rv;
    redirect_base = base;
    immext = imm;
    imem_bus.imem_ready = rdy;
    imem_bus.imem_rdata = rdata;
    #1;
    exp_req = !r && !m_first_after_rst && !m_just_redirected && !st && !rv;
    chk("imem_req", 64'(imem_bus.imem_req), 64'(exp_req));
    chk("imem_addr", 64'(imem_bus.imem_addr), 64'(m_pc));
    chk("instr", 64'(instr), 64'(m_instr));
    chk("instr_pc", 64'(instr_pc), 64'(m_instr_pc));
    chk("instr_valid", 64'(instr_valid), 64'(m_valid));
    chk("flush", 64'(flush), 64'(m_just_redirected));
`ifdef FETCH_CTRL_BRCNT_EN
    chk("branch_count", 64'(branch_count), 64'(m_brcnt));
`endif
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_instr = '0; m_instr_pc = 0; m_valid = 0;
      m_first_after_rst = 1; m_just_redirected = 0; m_brcnt = 0;
    end else begin
      if (rv && m_brcnt < 65535) m_brcnt++;
      if (rv) begin
        m_pc = int'((longint'(imm) + longint'(base)) % 256);
        m_valid = 0;
        m_just_redirected = 1;
        m_first_after_rst = 0;
      end else if (m_first_after_rst) begin
        m_first_after_rst = 0;
      end else if (m_just_redirected) begin
        m_just_redirected = 0;
      end else if (exp_req && rdy) begin
        m_instr = rdata;
        m_instr_pc = m_pc;
        m_valid = 1;
        m_pc = (m_pc + 4) % 256;
      end else if (!st) begin
        m_valid = 0;
      end
    end
  endtask

  initial begin
    bit r, st, rv, rdy;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_base = '0; immext = '0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rdata = '0;
    m_pc = 0; m_instr = '0; m_instr_pc = 0; m_valid = 0;
    m_first_after_rst = 1; m_just_redirected = 0; m_brcnt = 0;
    repeat (2) @(posedge clk);

    // Reset values, then boot and sequential fetch with ready held high.
    step(1, 0, 0, 8'h00, 32'h0, 1, $urandom);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 32'h0, 1, $urandom);
    #1;
    chk("seq_instr_pc", 64'(instr_pc), 64'h08);
    chk("seq_valid", 64'(instr_valid), 64'h1);
    step(0, 0, 0, 8'h00, 32'h0, 1, $urandom);

    // Stall at pc 0x10 holds everything, then fetch resumes at 0x10.
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 32'h0, 1, $urandom);
    step(0, 0, 0, 8'h00, 32'h0, 1, $urandom);
    #1;
    chk("resume_pc", 64'(instr_pc), 64'h10);

    // Redirect beats stall and ready: 0x20 + (-8) = 0x18.
    step(0, 1, 1, 8'h20, 32'hFFFF_FFF8, 1, $urandom);
    #1;
    chk("redir_target", 64'(imem_bus.imem_addr), 64'h18);
    chk("redir_flush", 64'(flush), 64'h1);
    chk("redir_valid", 64'(instr_valid), 64'h0);
    step(0, 0, 0, 8'h00, 32'h0, 1, $urandom);
    step(0, 0, 0, 8'h00, 32'h0, 1, $urandom);
    #1;
    chk("after_redir_pc", 64'(instr_pc), 64'h18);

    // Wrap: jump to 0xFC, fetch, pc becomes 0x00; then 0xF0 + 0x20 = 0x10.
    step(0, 0, 1, 8'hF0, 32'h0000_000C, 0, $urandom);
    step(0, 0, 0, 8'h00, 32'h0, 0, $urandom);
    step(0, 0, 0, 8'h00, 32'h0, 1, $urandom);
    #1;
    chk("wrap_pc", 64'(imem_bus.imem_addr), 64'h00);
    step(0, 0, 1, 8'hF0, 32'h0000_0020, 1, $urandom);
    #1;
    chk("wrap_target", 64'(imem_bus.imem_addr), 64'h10);

    // Slow memory: request and address hold until ready.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 32'h0, 0, $urandom);
    step(0, 0, 0, 8'h00, 32'h0, 1, $urandom);

    // Reset while in REDIRECT with ready and a new redirect pending.
    step(0, 0, 1, 8'h40, 32'h4, 1, $urandom);
    step(1, 0, 1, 8'h80, 32'h8, 1, $urandom);
    #1;
    chk("rst_addr", 64'(imem_bus.imem_addr), 64'h0);
    chk("rst_flush", 64'(flush), 64'h0);
    chk("rst_valid", 64'(instr_valid), 64'h0);
    step(0, 0, 0, 8'h00, 32'h0, 1, $urandom);
    #1;
    chk("reboot_valid", 64'(instr_valid), 64'h0);
    step(0, 0, 0, 8'h00, 32'h0, 1, $urandom);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      step(r, st, rv, 8'($urandom), $urandom, rdy, $urandom);
    end

`ifdef FETCH_CTRL_BRCNT_EN
    // Counter: three redirects, then saturation.
    step(1, 0, 0, 8'h00, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 8'h00, 32'h4, 1, $urandom);
      step(0, 0, 0, 8'h00, 32'h0, 1, $urandom);
    end
    #1;
    chk("brcnt_three", 64'(branch_count), 64'd3);
    for (int i = 0; i < 65540; i++) step(0, 0, 1, 8'($urandom), $urandom, 1, $urandom);
    #1;
    chk("brcnt_sat", 64'(branch_count), 64'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
